// File: rtl/serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_pkg : shared types and defaults for the bit-serial adder
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/serial_adder_bit_fa.sv
// ----------------------------------------------------------------------------
// bit_fa : combinational one-bit full adder cell
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module bit_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic s
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder : WIDTH-bit LSB-first bit-serial adder with valid/ready I/O.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              CW     = $clog2(WIDTH);
  localparam logic [1:0]      c_IDLE = IDLE;
  localparam logic [1:0]      c_RUN  = RUN;
  localparam logic [1:0]      c_DONE = DONE;
  localparam logic [CW-1:0]   c_LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             w_c;
  logic             w_s;

  bit_fa u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .cout (w_c),
    .s    (w_s)
  );

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // Carry into the MSB is the carry register during the final RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (r_state == c_RUN && r_cnt == c_LAST) begin
      r_ovf <= r_carry ^ w_c;
    end
  end

  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_c;
          if (r_cnt == c_LAST) begin
            r_cout  <= w_c;
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == c_IDLE);
  assign busy      = (r_state == c_RUN);
  assign out_valid = (r_state == c_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_adder : scoreboard bench for serial_adder (WIDTH=8)
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  wire          in_ready;
  wire          out_valid;
  wire          cout;
  wire          busy;
  wire  [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  wire          ovf;
`endif

  typedef struct packed {
    logic         ovf;
    logic         cout;
    logic [W-1:0] sum;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition; overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    exp_t        e;
    logic [W:0]  full;
    full   = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ta[W-1] == tb[W-1]) && (e.sum[W-1] != ta[W-1]);
    return e;
  endfunction

  // Monitor: pops on each new result, then checks it stays stable while held.
  initial begin : monitor
    exp_t cur;
    bit   have;
    have = 1'b0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (!have) begin
          if (q.size() == 0) begin
            chk("sb_unexpected_result", 32'd1, 32'd0);
          end else begin
            cur  = q.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          chk("sum", {24'd0, sum}, {24'd0, cur.sum});
          chk("cout", {31'd0, cout}, {31'd0, cur.cout});
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf", {31'd0, ovf}, {31'd0, cur.ovf});
`endif
        end
      end else begin
        have = 1'b0;
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input int hold, input bit flood);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    q.push_back(model(ta, tb, tc));
    @(posedge clk);
    #1;
    if (flood) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("out_valid_early", {31'd0, out_valid}, 32'd0);
      chk("in_ready_run", {31'd0, in_ready}, 32'd0);
      if (flood) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
    end
    @(negedge clk);
    chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("in_ready_done", {31'd0, in_ready}, 32'd0);
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      chk("out_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("in_ready_hold", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);

    run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 2, 1'b0);
    run_op(8'h7F, 8'h00, 1'b1, 0, 1'b0);
    run_op(8'hA5, 8'hC3, 1'b1, 5, 1'b0);
    run_op(8'h12, 8'h34, 1'b0, 1, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b0, 0, 1'b0);

    // Abort an operation at count 3; its result must never appear.
    a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_sum", {24'd0, sum}, 32'd0);
    chk("midrun_rst_cout", {31'd0, cout}, 32'd0);
    chk("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
    run_op(8'h01, 8'h01, 1'b0, 0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
